// File: rtl/register_file.sv
// register_file: 2**ADDR_W x DATA_W GPR file, two combinational read ports, one write port.
// Optional macro RF_BYPASS_EN forwards same-cycle write data to a matching read port.
module register_file #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data,
    input  logic [ADDR_W-1:0] addr_wr,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [ADDR_W-1:0] addr_b,
    output logic [DATA_W-1:0] q_a,
    output logic [DATA_W-1:0] q_b
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];

    // Storage: cleared at once by reset, otherwise written unconditionally each edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            regs[addr_wr] <= data;
        end
    end

`ifdef RF_BYPASS_EN
    logic hit_a;
    logic hit_b;

    // Forwarding only while out of reset, so outputs stay 0 during reset.
    always_comb begin
        hit_a = rst && (addr_a == addr_wr);
        hit_b = rst && (addr_b == addr_wr);
    end

    // Read ports: pending write data wins over stored contents on a match.
    always_comb begin
        q_a = regs[addr_a];
        q_b = regs[addr_b];
        if (hit_a) begin
            q_a = data;
        end
        if (hit_b) begin
            q_b = data;
        end
    end
`else
    // Read ports: stored contents only; a same-address write shows after the edge.
    always_comb begin
        q_a = regs[addr_a];
        q_b = regs[addr_b];
    end
`endif

endmodule

// File: tb/tb_register_file.sv
// tb_register_file: scoreboard bench for register_file.
// Expected read data is queued as stimulus is driven and checked when sampled.
module tb_register_file;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;

    logic              clk;
    logic              rst;
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] addr_wr;
    logic [ADDR_W-1:0] addr_a;
    logic [ADDR_W-1:0] addr_b;
    logic [DATA_W-1:0] q_a;
    logic [DATA_W-1:0] q_b;

    logic [DATA_W-1:0] sb_a[$];
    logic [DATA_W-1:0] sb_b[$];
    logic [DATA_W-1:0] exp_a;
    logic [DATA_W-1:0] exp_b;

    int n_vec  = 0;
    int n_miss = 0;

    register_file #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .data   (data),
        .addr_wr(addr_wr),
        .addr_a (addr_a),
        .addr_b (addr_b),
        .q_a    (q_a),
        .q_b    (q_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] fill_val(input int i);
        return DATA_W'(100 + 50 * i);
    endfunction

    task automatic test_reset();
        #3;
        sb_a.push_back('0);
        sb_b.push_back('0);
        exp_a = sb_a.pop_front();
        exp_b = sb_b.pop_front();
        n_vec += 2;
        if (q_a !== exp_a) begin
            n_miss++;
            $display("FAIL reset_init q_a got %h want %h", q_a, exp_a);
        end
        if (q_b !== exp_b) begin
            n_miss++;
            $display("FAIL reset_init q_b got %h want %h", q_b, exp_b);
        end
        // preload reg 2
        @(negedge clk);
        rst = 1'b1;
        addr_wr = 4'd2;
        data = 32'd77;
        @(posedge clk);
        #1;
        addr_a = 4'd2;
        addr_b = 4'd2;
        sb_a.push_back(32'd77);
        sb_b.push_back(32'd77);
        #1;
        exp_a = sb_a.pop_front();
        exp_b = sb_b.pop_front();
        n_vec += 2;
        if (q_a !== exp_a) begin
            n_miss++;
            $display("FAIL preload q_a got %h want %h", q_a, exp_a);
        end
        if (q_b !== exp_b) begin
            n_miss++;
            $display("FAIL preload q_b got %h want %h", q_b, exp_b);
        end
        // assert reset between edges
        @(negedge clk);
        #2;
        rst = 1'b0;
        sb_a.push_back('0);
        sb_b.push_back('0);
        #1;
        exp_a = sb_a.pop_front();
        exp_b = sb_b.pop_front();
        n_vec += 2;
        if (q_a !== exp_a) begin
            n_miss++;
            $display("FAIL reset_async q_a got %h want %h", q_a, exp_a);
        end
        if (q_b !== exp_b) begin
            n_miss++;
            $display("FAIL reset_async q_b got %h want %h", q_b, exp_b);
        end
        // writes during reset are dropped
        data = 32'd100;
        addr_wr = 4'd2;
        repeat (2) @(posedge clk);
        #1;
        sb_a.push_back('0);
        sb_b.push_back('0);
        exp_a = sb_a.pop_front();
        exp_b = sb_b.pop_front();
        n_vec += 2;
        if (q_a !== exp_a) begin
            n_miss++;
            $display("FAIL reset_hold q_a got %h want %h", q_a, exp_a);
        end
        if (q_b !== exp_b) begin
            n_miss++;
            $display("FAIL reset_hold q_b got %h want %h", q_b, exp_b);
        end
    endtask

    task automatic test_fill();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 16; i++) begin
            addr_wr = ADDR_W'(i);
            data = fill_val(i);
            @(posedge clk);
            #1;
        end
        addr_a = 4'd0;
        addr_b = 4'd1;
        sb_a.push_back(32'd100);
        sb_b.push_back(32'd150);
        #1;
        exp_a = sb_a.pop_front();
        exp_b = sb_b.pop_front();
        n_vec += 2;
        if (q_a !== exp_a) begin
            n_miss++;
            $display("FAIL fill q_a got %h want %h", q_a, exp_a);
        end
        if (q_b !== exp_b) begin
            n_miss++;
            $display("FAIL fill q_b got %h want %h", q_b, exp_b);
        end
    endtask

    task automatic test_sweep();
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            addr_a = ADDR_W'(2 * k);
            addr_b = ADDR_W'(2 * k + 1);
            sb_a.push_back(fill_val(2 * k));
            sb_b.push_back(fill_val(2 * k + 1));
            #1;
            exp_a = sb_a.pop_front();
            exp_b = sb_b.pop_front();
            n_vec += 2;
            if (q_a !== exp_a) begin
                n_miss++;
                $display("FAIL sweep%0d q_a got %h want %h", k, q_a, exp_a);
            end
            if (q_b !== exp_b) begin
                n_miss++;
                $display("FAIL sweep%0d q_b got %h want %h", k, q_b, exp_b);
            end
        end
    endtask

    task automatic test_same_addr();
        @(negedge clk);
        addr_a = 4'd7;
        addr_b = 4'd7;
        sb_a.push_back(32'd450);
        sb_b.push_back(32'd450);
        #1;
        exp_a = sb_a.pop_front();
        exp_b = sb_b.pop_front();
        n_vec += 2;
        if (q_a !== exp_a) begin
            n_miss++;
            $display("FAIL same_rd q_a got %h want %h", q_a, exp_a);
        end
        if (q_b !== exp_b) begin
            n_miss++;
            $display("FAIL same_rd q_b got %h want %h", q_b, exp_b);
        end
        addr_wr = 4'd7;
        data = 32'hFFFF_FFFF;
        sb_a.push_back(32'hFFFF_FFFF);
        sb_b.push_back(32'hFFFF_FFFF);
        @(posedge clk);
        #1;
        exp_a = sb_a.pop_front();
        exp_b = sb_b.pop_front();
        n_vec += 2;
        if (q_a !== exp_a) begin
            n_miss++;
            $display("FAIL same_wr q_a got %h want %h", q_a, exp_a);
        end
        if (q_b !== exp_b) begin
            n_miss++;
            $display("FAIL same_wr q_b got %h want %h", q_b, exp_b);
        end
        addr_wr = 4'd15;
        data = 32'd850;
    endtask

    task automatic test_rdw();
        @(negedge clk);
        addr_a = 4'd3;
        addr_b = 4'd4;
        addr_wr = 4'd3;
        data = 32'd999;
`ifdef RF_BYPASS_EN
        sb_a.push_back(32'd999);
`else
        sb_a.push_back(32'd250);
`endif
        sb_b.push_back(32'd300);
        #1;
        exp_a = sb_a.pop_front();
        exp_b = sb_b.pop_front();
        n_vec += 2;
        if (q_a !== exp_a) begin
            n_miss++;
            $display("FAIL rdw_pre q_a got %h want %h", q_a, exp_a);
        end
        if (q_b !== exp_b) begin
            n_miss++;
            $display("FAIL rdw_pre q_b got %h want %h", q_b, exp_b);
        end
        sb_a.push_back(32'd999);
        sb_b.push_back(32'd300);
        @(posedge clk);
        #1;
        exp_a = sb_a.pop_front();
        exp_b = sb_b.pop_front();
        n_vec += 2;
        if (q_a !== exp_a) begin
            n_miss++;
            $display("FAIL rdw_post q_a got %h want %h", q_a, exp_a);
        end
        if (q_b !== exp_b) begin
            n_miss++;
            $display("FAIL rdw_post q_b got %h want %h", q_b, exp_b);
        end
        addr_wr = 4'd15;
        data = 32'd850;
    endtask

    task automatic test_continuous();
        @(negedge clk);
        addr_a = 4'd5;
        addr_b = 4'd6;
        addr_wr = 4'd5;
        for (int v = 1; v <= 3; v++) begin
            data = DATA_W'(v);
            sb_a.push_back(DATA_W'(v));
            sb_b.push_back(32'd400);
            @(posedge clk);
            #1;
            exp_a = sb_a.pop_front();
            exp_b = sb_b.pop_front();
            n_vec += 2;
            if (q_a !== exp_a) begin
                n_miss++;
                $display("FAIL cont%0d q_a got %h want %h", v, q_a, exp_a);
            end
            if (q_b !== exp_b) begin
                n_miss++;
                $display("FAIL cont%0d q_b got %h want %h", v, q_b, exp_b);
            end
        end
        addr_wr = 4'd15;
        data = 32'd850;
    endtask

    task automatic test_no_disturb();
        logic [DATA_W-1:0] gold [16];
        for (int i = 0; i < 16; i++) begin
            gold[i] = fill_val(i);
        end
        gold[3] = 32'd999;
        gold[5] = 32'd3;
        gold[7] = 32'hFFFF_FFFF;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            addr_a = ADDR_W'(i);
            addr_b = ADDR_W'(15 - i);
            sb_a.push_back(gold[i]);
            sb_b.push_back(gold[15 - i]);
            #1;
            exp_a = sb_a.pop_front();
            exp_b = sb_b.pop_front();
            n_vec += 2;
            if (q_a !== exp_a) begin
                n_miss++;
                $display("FAIL final%0d q_a got %h want %h", i, q_a, exp_a);
            end
            if (q_b !== exp_b) begin
                n_miss++;
                $display("FAIL final%0d q_b got %h want %h", i, q_b, exp_b);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        data = '0;
        addr_wr = '0;
        addr_a = '0;
        addr_b = '0;
        test_reset();
        test_fill();
        test_sweep();
        test_same_addr();
        test_rdw();
        test_continuous();
        test_no_disturb();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
